// File: rtl/uplink_tx_gearbox_if.sv
// uplink_tx_gearbox_if: frame-side valid/ready handshake between frame assembly and the gearbox.
interface uplink_tx_gearbox_if #(
  parameter int FRAME_WIDTH = 64
);
  logic [FRAME_WIDTH-1:0] frame_in;
  logic frame_valid;
  logic frame_ready;
  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/uplink_tx_gearbox.sv
// uplink_tx_gearbox: frame-to-word gearbox with 1-deep holding buffer, idle insertion and underflow count.
module uplink_tx_gearbox #(
  parameter int FRAME_WIDTH = 64,
  parameter int WORD_WIDTH = 16,
  parameter logic [FRAME_WIDTH-1:0] IDLE_FRAME = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  uplink_tx_gearbox_if.slave frame_if,
  output logic frame_req,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic underflow,
  output logic [CNT_WIDTH-1:0] underflow_count,
  input  logic clear_counters
);
  localparam int RATIO = FRAME_WIDTH / WORD_WIDTH;
  localparam int PW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);
  logic [PW-1:0] phase;
  logic [FRAME_WIDTH-1:0] shreg, pend;
  logic pend_full, load, capture;
  assign load = enable && phase == LAST;
  // ready depends only on buffer state and phase, never on frame_valid
  assign frame_if.frame_ready = !pend_full || load;
  assign capture = enable && frame_if.frame_valid && frame_if.frame_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      shreg <= IDLE_FRAME;
      pend <= '0;
      pend_full <= 1'b0;
      word_out <= '0;
      frame_req <= 1'b0;
      underflow <= 1'b0;
      underflow_count <= '0;
    end else begin
      if (enable) begin
        phase <= load ? '0 : phase + 1'b1;
        word_out <= shreg[FRAME_WIDTH-1 -: WORD_WIDTH];
        shreg <= load ? (pend_full ? pend : IDLE_FRAME) : shreg << WORD_WIDTH;
        frame_req <= load;
        pend_full <= capture || (pend_full && !load);
        if (capture) pend <= frame_if.frame_in;
      end
      if (clear_counters) begin
        underflow <= 1'b0;
        underflow_count <= '0;
      end else if (load && !pend_full) begin
        underflow <= 1'b1;
        underflow_count <= &underflow_count ? underflow_count : underflow_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uplink_tx_gearbox.sv
// tb_uplink_tx_gearbox: directed table-driven bench for the uplink gearbox (RATIO=4, 2-bit counter).
module tb_uplink_tx_gearbox;
  localparam int FW = 64;
  localparam int WW = 16;
  localparam int CW = 2;
  localparam logic [63:0] F1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] F2 = 64'hFEDCBA9876543210;
  typedef struct {
    logic v;
    logic [63:0] d;
    logic rdy;
    logic [15:0] w;
    logic req;
    logic uf;
    logic [1:0] cnt;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear_counters = 1'b0;
  logic frame_req, underflow;
  logic [WW-1:0] word_out;
  logic [CW-1:0] underflow_count;
  logic [15:0] w [13];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  uplink_tx_gearbox_if #(.FRAME_WIDTH(FW)) fif ();
  uplink_tx_gearbox #(
    .FRAME_WIDTH(FW), .WORD_WIDTH(WW), .IDLE_FRAME(64'h0), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .frame_if(fif.slave),
    .frame_req(frame_req), .word_out(word_out), .underflow(underflow),
    .underflow_count(underflow_count), .clear_counters(clear_counters)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [63:0] d, input logic rdy, input logic [15:0] wd,
                     input logic req, input logic uf, input logic [1:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.w = wd; r.req = req; r.uf = uf; r.cnt = cnt;
    tbl.push_back(r);
  endtask
  // called at posedge+1: drive inputs, sample ready, advance one edge, return at posedge+1
  task automatic cyc(input logic v, input logic [63:0] d, input logic en, input logic clr, output logic rdy);
    fif.frame_valid = v;
    fif.frame_in = d;
    enable = en;
    clear_counters = clr;
    #1 rdy = fif.frame_ready;
    @(posedge clock);
    #1;
  endtask
  task automatic stream(input bit tog);
    int idx = 0;
    int e = 0;
    logic r, en;
    for (int j = 0; e < 12; j++) begin
      en = !tog || j % 2 == 0;
      cyc(idx < 2, idx == 0 ? F1 : F2, en, 1'b0, r);
      if (idx < 2 && r && en) idx++;
      if (en) e++;
      chk("stream_word", word_out, w[e]);
      chk("stream_req", frame_req, e == 4 || e == 8 || e == 12);
    end
    chk("stream_captures", idx, 2);
    chk("stream_uf", underflow, 1);
    chk("stream_cnt", underflow_count, 1);
  endtask
  task automatic do_reset();
    fif.frame_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_word", word_out, 0);
    chk("rst_req", frame_req, 0);
    chk("rst_ready", fif.frame_ready, 1);
    chk("rst_uf", underflow, 0);
    chk("rst_cnt", underflow_count, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic r;
    logic [15:0] sq;
    w = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
          16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    add(1, F1, 1, 16'h0000, 0, 0, 0);
    add(1, F2, 0, 16'h0000, 0, 0, 0);
    add(1, F2, 0, 16'h0000, 0, 0, 0);
    add(1, F2, 1, 16'h0000, 1, 0, 0);
    add(0, 0, 0, 16'h0123, 0, 0, 0);
    add(0, 0, 0, 16'h4567, 0, 0, 0);
    add(0, 0, 0, 16'h89AB, 0, 0, 0);
    add(0, 0, 1, 16'hCDEF, 1, 0, 0);
    add(0, 0, 1, 16'hFEDC, 0, 0, 0);
    add(0, 0, 1, 16'hBA98, 0, 0, 0);
    add(0, 0, 1, 16'h7654, 0, 0, 0);
    add(0, 0, 1, 16'h3210, 1, 1, 1);
    for (int k = 13; k <= 24; k++)
      add(0, 0, 1, 16'h0000, k % 4 == 0, 1, k < 16 ? 2'd1 : k < 20 ? 2'd2 : 2'd3);
    fif.frame_valid = 1'b0;
    fif.frame_in = '0;
    @(posedge clock);
    #1;
    chk("reset_word", word_out, 0);
    chk("reset_req", frame_req, 0);
    chk("reset_uf", underflow, 0);
    chk("reset_cnt", underflow_count, 0);
    reset_n = 1'b1;
    // continuous supply followed by starvation
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, 1'b1, 1'b0, r);
      chk($sformatf("tbl%0d_ready", i), r, tbl[i].rdy);
      chk($sformatf("tbl%0d_word", i), word_out, tbl[i].w);
      chk($sformatf("tbl%0d_req", i), frame_req, tbl[i].req);
      chk($sformatf("tbl%0d_uf", i), underflow, tbl[i].uf);
      chk($sformatf("tbl%0d_cnt", i), underflow_count, tbl[i].cnt);
    end
    // saturation: 5th underflow keeps count at 3, clear wins against the 6th
    for (int k = 0; k < 4; k++) cyc(1'b0, 64'h0, 1'b1, 1'b0, r);
    chk("sat_cnt", underflow_count, 3);
    chk("sat_uf", underflow, 1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 64'h0, 1'b1, 1'b0, r);
    cyc(1'b0, 64'h0, 1'b1, 1'b1, r);
    chk("clr_wins_cnt", underflow_count, 0);
    chk("clr_wins_uf", underflow, 0);
    // backpressure: valid held high, sequence number in every word
    sq = 16'd0;
    for (int i = 0; i <= 30; i++) begin
      cyc(1'b1, {4{sq}}, 1'b1, 1'b0, r);
      chk($sformatf("bp%0d_ready", i), r, i == 0 || i % 4 == 3);
      if (r) sq++;
      chk($sformatf("bp%0d_word", i), word_out, i < 4 ? 16'd0 : 16'((i - 4) / 4));
    end
    chk("bp_captures", sq, 8);
    chk("bp_cnt", underflow_count, 0);
    chk("bp_uf", underflow, 0);
    // async reset in the middle of word 2, then a clean restart
    do_reset();
    stream(1'b0);
    // enable toggling stretches the same sequence
    do_reset();
    stream(1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b1, r);
    chk("clr_disabled_uf", underflow, 0);
    chk("clr_disabled_cnt", underflow_count, 0);
    chk("disabled_word_hold", word_out, 16'h3210);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uplink_tx_gearbox.md
Name: uplink_tx_gearbox

Overview:
- Downstream neighbour of the uplink scrambler; sits between frame assembly (header + scrambled payload + FEC) and the serializer.
- Accepts one FRAME_WIDTH-bit frame per frame period through a valid/ready handshake with a 1-deep holding buffer.
- Emits the frame as RATIO = FRAME_WIDTH/WORD_WIDTH words, MSB-first, one word per enabled clock.
- Generates the per-frame request pulse that drives the upstream scrambler's enable. Inserts an idle frame and counts underflows when no frame is ready.

Parameters:
FRAME_WIDTH, 64, frame width in bits; must be an integer multiple of WORD_WIDTH.
WORD_WIDTH, 16, serializer word width in bits.
IDLE_FRAME, 64'h0000_0000_0000_0000, frame transmitted when no frame is pending; width FRAME_WIDTH.
CNT_WIDTH, 16, width of the underflow counter.

Ports:
clock  in  1  single clock, all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  clock enable for the whole datapath; when low, all state holds.
frame_in  in  FRAME_WIDTH  frame to transmit.
frame_valid  in  1  frame_in is valid.
frame_ready  out  1  holding buffer can accept a frame this cycle.
frame_req  out  1  one-cycle pulse per frame period; upstream scrambler enable.
word_out  out  WORD_WIDTH  serializer word, registered.
underflow  out  1  sticky; set when an idle frame was inserted.
underflow_count  out  CNT_WIDTH  saturating count of idle insertions.
clear_counters  in  1  synchronous clear of underflow and underflow_count.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - phase = 0, shift register = IDLE_FRAME, pending buffer empty.
  - word_out = 0, frame_req = 0, underflow = 0, underflow_count = 0.
- Phase counter: counts 0 to RATIO-1 on each enabled edge, then wraps to 0.
- Load: occurs on the enabled edge where phase == RATIO-1.
  - Pending full: shift register <= pending, pending becomes empty.
  - Pending empty: shift register <= IDLE_FRAME; underflow <= 1; underflow_count increments and saturates at all-ones.
- Other enabled edges: shift register shifts left by WORD_WIDTH.
- Output: on every enabled edge, word_out <= shift register [FRAME_WIDTH-1 -: WORD_WIDTH].
  - Word k of a frame appears on word_out after edge (load edge + 1 + k).
  - Latency from load to first word = 1 enabled clock.
- Handshake:
  - frame_ready = (pending empty) OR (load on this edge). Combinational, but with no combinational path from frame_valid.
  - A frame is captured when frame_valid && frame_ready && enable.
  - Simultaneous load and capture: the shift register takes the old pending frame and pending takes the new frame.
  - frame_valid with frame_ready=0: the frame is not taken; the source must hold it.
- frame_req: registered; equals 1 in exactly the enabled cycle following each load edge (phase == 0), giving one pulse per RATIO enabled cycles. It stays high while enable=0 during that cycle.
- Counters:
  - clear_counters=1 zeroes underflow and underflow_count on the next edge regardless of enable.
  - If clear_counters and an underflow coincide, clear wins.
- enable=0: phase, shift register, pending, word_out and counters all hold; capture is inhibited.
- First frame after reset: the first load occurs at the RATIO-th enabled edge. IDLE_FRAME words are output until then.
- Reset mid-frame: the partial frame and pending frame are discarded; output restarts per the reset values.

Test Plan:
1. Continuous supply, RATIO=4: present frames 64'h0123456789ABCDEF then 64'hFEDCBA9876543210 whenever frame_ready=1 -> word_out = 0123, 4567, 89AB, CDEF, FEDC, BA98, 7654, 3210 on consecutive enabled cycles; underflow stays 0.
2. Starvation: hold frame_valid=0 for 3 frame periods after one frame -> 3 IDLE_FRAMEs output (12 words of 0000), underflow=1, underflow_count=3.
3. Saturation with CNT_WIDTH=2: 5 starved periods -> count 3; then assert clear_counters together with a 6th underflow -> count 0, underflow 0.
4. Backpressure: frame_valid held high continuously -> exactly one capture per load edge; frame_ready=0 on the other cycles; no frame dropped or duplicated (check via a sequence number in frame_in).
5. enable toggling 1,0,1,0: word sequence identical to test 1 but stretched; frame_req pulses once per 4 enabled cycles.
6. Assert reset_n=0 asynchronously during word 2 of a frame -> word_out=0 immediately. After release, idle words until the first load, then the next supplied frame starts cleanly at word 0.
